// File: rtl/lcd_char_writer_if.sv
// lcd_char_writer_if
//   Write-request channel from user logic into lcd_char_writer.
//   The master (user logic) drives in_valid, in_rs and in_data.
//   The slave (lcd_char_writer) drives in_ready.
//   A write transfers on a cycle where in_valid && in_ready.
//   Signals:
//     in_valid  master -> slave  write request
//     in_ready  slave -> master  writer can accept a write
//     in_rs     master -> slave  0 = command, 1 = character data
//     in_data   master -> slave  command or character byte
interface lcd_char_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// lcd_char_writer
//   HD44780-class LCD controller. After power-up it runs the init sequence.
//   It then accepts command and character writes over a valid/ready channel.
//   Each write goes out on an 8-bit or 4-bit bus with programmable en timing.
//   The block tracks the cursor and wraps to the next line automatically.
//   Optional feature macro: LCD_BUSY_POLL_EN. When it is defined, each
//   post-init write is followed by a busy-flag poll instead of a fixed wait.
//   Ports:
//     clk      system clock
//     rstBt    asynchronous active-high reset
//     bus      write channel (lcd_char_writer_if.slave)
//     LCD      LCD data bus drive value (BUS_W bits)
//     LCD_oe   1 = drive the LCD bus, 0 = release it for reads
//     LCD_in   LCD bus readback (used only by the busy poll)
//     en       LCD enable strobe
//     RS       LCD register select
//     RW       LCD read/write (1 = read)
//     busy     init sequence in progress
//     cur_row  tracked cursor row
//     cur_col  tracked cursor column
//   All outputs are registered.
module lcd_char_writer #(
    parameter int CLK_HZ  = 50000000,
    parameter int BUS_W   = 8,
    parameter int COLS    = 16,
    parameter int ROWS    = 2,
    parameter int EN_CYC  = 25,
    parameter int CMD_CYC = 2500,
    parameter int CLR_CYC = 82000,
    parameter int PWR_CYC = 750000
) (
    input  logic                       clk,
    input  logic                       rstBt,
    lcd_char_writer_if.slave           bus,
    output logic [BUS_W-1:0]           LCD,
    output logic                       LCD_oe,
    input  logic [BUS_W-1:0]           LCD_in,
    output logic                       en,
    output logic                       RS,
    output logic                       RW,
    output logic                       busy,
    output logic                       cur_row,
    output logic [$clog2(COLS+1)-1:0]  cur_col
);
    localparam int          CW        = $clog2(COLS + 1);
    localparam logic [31:0] EN_LAST   = 32'(EN_CYC - 1);
    localparam logic [31:0] CMD_LAST  = 32'(CMD_CYC - 1);
    localparam logic [31:0] CLR_LAST  = 32'(CLR_CYC - 1);
    localparam logic [31:0] PWR_LAST  = 32'(PWR_CYC - 1);
    localparam logic [31:0] CLK_HZ_L  = 32'(CLK_HZ);
    localparam logic [3:0]  INIT_N    = (BUS_W == 4) ? 4'd8 : 4'd7;
    localparam logic [CW-1:0] COL_FULL = CW'(COLS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [7:0]  FSET8     = (ROWS == 1) ? 8'h30 : 8'h38;
    localparam logic [7:0]  FSET4     = (ROWS == 1) ? 8'h20 : 8'h28;

    typedef enum logic [3:0] {
        S_PWR_WAIT   = 4'd0,
        S_INIT       = 4'd1,
        S_IDLE       = 4'd2,
        S_SETUP      = 4'd3,
        S_EN_HI      = 4'd4,
        S_EN_LO      = 4'd5,
        S_WAIT       = 4'd6
`ifdef LCD_BUSY_POLL_EN
        ,
        S_POLL_SETUP = 4'd7,
        S_POLL_HI    = 4'd8,
        S_POLL_LO    = 4'd9
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [7:0]  r_byte;       // byte currently on the bus (needed for the low nibble)
    logic        r_second;     // 4-bit mode: low nibble / second poll nibble in progress
    logic        r_single;     // 4-bit init nibble sent with a single strobe
    logic        r_long;       // current write needs the clear/home wait
    logic [3:0]  r_init_idx;
    logic        r_init_done;
    logic        r_pend_char;  // character held back behind an auto-wrap command
    logic [7:0]  r_pend_byte;
    logic        r_in_ready;
`ifdef LCD_BUSY_POLL_EN
    logic        r_bf;         // busy flag sampled during the poll
`endif
    logic        w_next_row;
    logic [7:0]  w_wrap_cmd;
    logic        w_unused_sink;

    // Init bytes; 4-bit mode starts with four single-nibble strobes 3,3,3,2.
    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (BUS_W == 4) begin
            case (idx)
                4'd0, 4'd1, 4'd2: b = 8'h30;
                4'd3:             b = 8'h20;
                4'd4:             b = FSET4;
                4'd5:             b = 8'h0C;
                4'd6:             b = 8'h06;
                4'd7:             b = 8'h01;
                default:          b = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0, 4'd1, 4'd2, 4'd3: b = FSET8;
                4'd4:                   b = 8'h0C;
                4'd5:                   b = 8'h06;
                4'd6:                   b = 8'h01;
                default:                b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Value placed on the bus: the whole byte, or the selected nibble in 4-bit mode.
    function automatic logic [BUS_W-1:0] bus_val(input logic [7:0] b, input logic lo);
        logic [7:0] t;
        if (BUS_W == 8) begin
            t = b;
        end else if (lo) begin
            t = {4'h0, b[3:0]};
        end else begin
            t = {4'h0, b[7:4]};
        end
        return t[BUS_W-1:0];
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long post-write wait.
    function automatic logic is_long(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

    assign w_next_row    = (ROWS == 2) ? ~cur_row : 1'b0;
    assign w_wrap_cmd    = w_next_row ? 8'hC0 : 8'h80;
    assign bus.in_ready  = r_in_ready;
    assign w_unused_sink = ^{LCD_in, CLK_HZ_L};

    // Main controller FSM: init sequence, write strobes, waits, cursor tracking.
    always_ff @(posedge clk or posedge rstBt) begin
        if (rstBt) begin
            r_state     <= S_PWR_WAIT;
            r_cnt       <= 32'd0;
            r_byte      <= 8'h00;
            r_second    <= 1'b0;
            r_single    <= 1'b0;
            r_long      <= 1'b0;
            r_init_idx  <= 4'd0;
            r_init_done <= 1'b0;
            r_pend_char <= 1'b0;
            r_pend_byte <= 8'h00;
            r_in_ready  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            r_bf        <= 1'b0;
`endif
            LCD         <= '0;
            LCD_oe      <= 1'b1;
            en          <= 1'b0;
            RS          <= 1'b0;
            RW          <= 1'b0;
            busy        <= 1'b1;
            cur_row     <= 1'b0;
            cur_col     <= '0;
        end else begin
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_cnt == PWR_LAST) begin
                        r_cnt   <= 32'd0;
                        r_state <= S_INIT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_INIT: begin
                    r_byte     <= init_byte(r_init_idx);
                    r_single   <= (BUS_W == 4) && (r_init_idx < 4'd4);
                    r_long     <= is_long(1'b0, init_byte(r_init_idx));
                    r_second   <= 1'b0;
                    RS         <= 1'b0;
                    LCD        <= bus_val(init_byte(r_init_idx), 1'b0);
                    r_init_idx <= r_init_idx + 4'd1;
                    r_cnt      <= 32'd0;
                    r_state    <= S_SETUP;
                end
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_second   <= 1'b0;
                        r_single   <= 1'b0;
                        r_cnt      <= 32'd0;
                        r_state    <= S_SETUP;
                        if (bus.in_rs && cur_col == COL_FULL) begin
                            // Line full: move to the next line first, hold the character.
                            r_byte      <= w_wrap_cmd;
                            RS          <= 1'b0;
                            LCD         <= bus_val(w_wrap_cmd, 1'b0);
                            r_long      <= 1'b0;
                            r_pend_char <= 1'b1;
                            r_pend_byte <= bus.in_data;
                            cur_row     <= w_next_row;
                            cur_col     <= '0;
                        end else begin
                            r_byte <= bus.in_data;
                            RS     <= bus.in_rs;
                            LCD    <= bus_val(bus.in_data, 1'b0);
                            r_long <= is_long(bus.in_rs, bus.in_data);
                            if (bus.in_rs) begin
                                cur_col <= cur_col + CW'(1);
                            end else if (is_long(bus.in_rs, bus.in_data)) begin
                                cur_row <= 1'b0;
                                cur_col <= '0;
                            end else if (bus.in_data[7]) begin
                                cur_row <= bus.in_data[6];
                                if ({1'b0, bus.in_data[5:0]} >= 7'(COLS - 1)) begin
                                    cur_col <= COL_LAST;
                                end else begin
                                    cur_col <= CW'(bus.in_data[5:0]);
                                end
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 32'd1) begin
                        en      <= 1'b1;
                        r_cnt   <= 32'd0;
                        r_state <= S_EN_HI;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_EN_HI: begin
                    if (r_cnt == EN_LAST) begin
                        en      <= 1'b0;
                        r_cnt   <= 32'd0;
                        r_state <= S_EN_LO;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_EN_LO: begin
                    if (r_cnt == EN_LAST) begin
                        r_cnt <= 32'd0;
                        if (BUS_W == 4 && !r_single && !r_second) begin
                            r_second <= 1'b1;
                            LCD      <= bus_val(r_byte, 1'b1);
                            r_state  <= S_SETUP;
`ifdef LCD_BUSY_POLL_EN
                        end else if (r_init_done) begin
                            RS       <= 1'b0;
                            RW       <= 1'b1;
                            LCD_oe   <= 1'b0;
                            r_second <= 1'b0;
                            r_state  <= S_POLL_SETUP;
`endif
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == (r_long ? CLR_LAST : CMD_LAST)) begin
                        r_cnt <= 32'd0;
                        if (!r_init_done) begin
                            if (r_init_idx == INIT_N) begin
                                r_init_done <= 1'b1;
                                r_in_ready  <= 1'b1;
                                busy        <= 1'b0;
                                r_state     <= S_IDLE;
                            end else begin
                                r_state <= S_INIT;
                            end
                        end else if (r_pend_char) begin
                            r_pend_char <= 1'b0;
                            r_byte      <= r_pend_byte;
                            RS          <= 1'b1;
                            LCD         <= bus_val(r_pend_byte, 1'b0);
                            r_long      <= 1'b0;
                            r_second    <= 1'b0;
                            cur_col     <= cur_col + CW'(1);
                            r_state     <= S_SETUP;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
`ifdef LCD_BUSY_POLL_EN
                S_POLL_SETUP: begin
                    if (r_cnt == 32'd1) begin
                        en      <= 1'b1;
                        r_cnt   <= 32'd0;
                        r_state <= S_POLL_HI;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_POLL_HI: begin
                    if (r_cnt == EN_LAST) begin
                        // The busy flag lives in the first (high) nibble only.
                        if (!r_second) begin
                            r_bf <= LCD_in[BUS_W-1];
                        end
                        en      <= 1'b0;
                        r_cnt   <= 32'd0;
                        r_state <= S_POLL_LO;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_POLL_LO: begin
                    if (r_cnt == EN_LAST) begin
                        r_cnt <= 32'd0;
                        if (BUS_W == 4 && !r_second) begin
                            r_second <= 1'b1;
                            r_state  <= S_POLL_SETUP;
                        end else if (r_bf) begin
                            r_second <= 1'b0;
                            r_state  <= S_POLL_SETUP;
                        end else begin
                            RW       <= 1'b0;
                            LCD_oe   <= 1'b1;
                            r_second <= 1'b0;
                            if (r_pend_char) begin
                                r_pend_char <= 1'b0;
                                r_byte      <= r_pend_byte;
                                RS          <= 1'b1;
                                LCD         <= bus_val(r_pend_byte, 1'b0);
                                r_long      <= 1'b0;
                                cur_col     <= cur_col + CW'(1);
                                r_state     <= S_SETUP;
                            end else begin
                                r_in_ready <= 1'b1;
                                r_state    <= S_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
`endif
                default: begin
                    r_cnt   <= 32'd0;
                    r_state <= S_PWR_WAIT;
                end
            endcase
        end
    end
endmodule
